// File: rtl/rc5_s_table_arbiter_pkg.sv
// Shared definitions for the RC5 expanded-key table and its arbiter:
// FSM state encoding, requester indices and table geometry helpers.
package rc5_s_table_arbiter_pkg;

  localparam int W_DEFAULT = 32;
  localparam int R_DEFAULT = 12;

  // Requester indices into iReq / oGnt.
  localparam int REQ_CIPHER   = 0;
  localparam int REQ_DECIPHER = 1;

  typedef enum logic [1:0] {
    KEY_LOAD = 2'd0,
    IDLE     = 2'd1,
    GRANT_C  = 2'd2,
    GRANT_D  = 2'd3
  } stateT;

  // Table depth: two words per round plus the pre-whitening pair.
  function automatic int tDepth(input int rounds);
    return 2 * (rounds + 1);
  endfunction

  function automatic int tLength(input int rounds);
    return $clog2(tDepth(rounds));
  endfunction

endpackage

// File: rtl/rc5_s_table_arbiter_if.sv
// Bus between the S-table arbiter and its clients: key-expansion write/read
// side plus the two round-engine request/address/data channels.
interface rc5_s_table_arbiter_if
  import rc5_s_table_arbiter_pkg::*;
#(
  parameter int W = W_DEFAULT,
  parameter int R = R_DEFAULT
);

  localparam int T_LENGTH = tLength(R);

  // Key-expansion side
  logic                iKey_start;
  logic                iKey_we;
  logic [T_LENGTH-1:0] iKey_waddr;
  logic [W-1:0]        iKey_wdata;
  logic [T_LENGTH-1:0] iKey_raddr;
  logic                iKey_done;
  logic                oKey_valid;

  // Round-engine side
  logic [1:0]          iReq;
  logic [T_LENGTH-1:0] iAddr1_c;
  logic [T_LENGTH-1:0] iAddr2_c;
  logic [T_LENGTH-1:0] iAddr1_d;
  logic [T_LENGTH-1:0] iAddr2_d;
  logic [1:0]          oGnt;
  logic [W-1:0]        oS_sub_i1;
  logic [W-1:0]        oS_sub_i2;

  // Clients (key expansion + engines)
  modport master (
    output iKey_start, iKey_we, iKey_waddr, iKey_wdata, iKey_raddr, iKey_done,
    output iReq, iAddr1_c, iAddr2_c, iAddr1_d, iAddr2_d,
    input  oKey_valid, oGnt, oS_sub_i1, oS_sub_i2
  );

  // Arbiter
  modport slave (
    input  iKey_start, iKey_we, iKey_waddr, iKey_wdata, iKey_raddr, iKey_done,
    input  iReq, iAddr1_c, iAddr2_c, iAddr1_d, iAddr2_d,
    output oKey_valid, oGnt, oS_sub_i1, oS_sub_i2
  );

endinterface

// File: rtl/rc5_s_table_arbiter_ram.sv
// T x W key table: one write port, two synchronous read ports with
// enables. Out-of-range reads return zero; out-of-range writes are dropped.
module rc5_s_ram #(
  parameter int W  = 32,
  parameter int T  = 26,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          rdEn1,
  input  logic [AW-1:0] raddr1,
  input  logic          rdEn2,
  input  logic [AW-1:0] raddr2,
  output logic [W-1:0]  rdata1,
  output logic [W-1:0]  rdata2
);

  localparam logic [AW:0] DEPTH = (AW + 1)'(T);

  logic [W-1:0] mem [T];

  logic wInRange;
  logic r1InRange;
  logic r2InRange;

  assign wInRange  = {1'b0, waddr}  < DEPTH;
  assign r1InRange = {1'b0, raddr1} < DEPTH;
  assign r2InRange = {1'b0, raddr2} < DEPTH;

  // Table storage write.
  // NOTE: the storage array sits in its own block with no reset so it maps
  // onto RAM; only the read registers below are cleared by rst.
  always_ff @(posedge clk) begin
    if (we && wInRange) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read ports; hold their value when not enabled.
  // NOTE: non-blocking assignments here and in the write block give
  // read-before-write on a same-address collision without extra logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata1 <= '0;
      rdata2 <= '0;
    end else begin
      if (rdEn1) rdata1 <= r1InRange ? mem[raddr1] : '0;
      if (rdEn2) rdata2 <= r2InRange ? mem[raddr2] : '0;
    end
  end

endmodule

// File: rtl/rc5_s_table_arbiter.sv
// Owns the RC5 S table, lets key expansion fill it, then shares it between
// the cipher and decipher round engines with a round-robin, hold-until-
// release grant. A new key request during a grant waits for the release.
module rc5_s_table_arbiter
  import rc5_s_table_arbiter_pkg::*;
#(
  parameter int W = W_DEFAULT,
  parameter int R = R_DEFAULT
) (
  input logic                  clk,
  input logic                  rst,
  rc5_s_table_arbiter_if.slave bus
);

  localparam int T        = tDepth(R);
  localparam int T_LENGTH = tLength(R);

  stateT      state, stateNxt;
  logic [1:0] gnt, gntNxt;
  logic       keyValid, keyValidNxt;
  logic       rLast, rLastNxt;
  logic       rKeyPend, rKeyPendNxt;

  logic                rdEn1, rdEn2;
  logic [T_LENGTH-1:0] raddr1, raddr2;
  logic                ramWe;
  logic                takeDecipher;

  // Both engines asking: serve the one that did not go last.
  assign takeDecipher = bus.iReq[REQ_DECIPHER] &&
                        (!bus.iReq[REQ_CIPHER] || (rLast == 1'b0));

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= KEY_LOAD;
      gnt      <= '0;
      keyValid <= 1'b0;
      rLast    <= 1'b1;
      rKeyPend <= 1'b0;
    end else begin
      state    <= stateNxt;
      gnt      <= gntNxt;
      keyValid <= keyValidNxt;
      rLast    <= rLastNxt;
      rKeyPend <= rKeyPendNxt;
    end
  end

  // Next-state and registered-output decode.
  // NOTE: every output of this block takes its hold value first, so no
  // branch can leave one unassigned and infer a latch.
  always_comb begin
    stateNxt    = state;
    gntNxt      = gnt;
    keyValidNxt = keyValid;
    rLastNxt    = rLast;
    rKeyPendNxt = rKeyPend;
    case (state)
      KEY_LOAD: begin
        if (bus.iKey_done) begin
          stateNxt    = IDLE;
          keyValidNxt = 1'b1;
        end
      end
      IDLE: begin
        if (rKeyPend || bus.iKey_start) begin
          stateNxt    = KEY_LOAD;
          keyValidNxt = 1'b0;
          rKeyPendNxt = 1'b0;
        end else if (takeDecipher) begin
          stateNxt = GRANT_D;
          gntNxt   = 2'b10;
        end else if (bus.iReq[REQ_CIPHER]) begin
          stateNxt = GRANT_C;
          gntNxt   = 2'b01;
        end
      end
      GRANT_C: begin
        if (bus.iKey_start) rKeyPendNxt = 1'b1;
        if (!bus.iReq[REQ_CIPHER]) begin
          stateNxt = IDLE;
          gntNxt   = '0;
          rLastNxt = 1'b0;
        end
      end
      GRANT_D: begin
        if (bus.iKey_start) rKeyPendNxt = 1'b1;
        if (!bus.iReq[REQ_DECIPHER]) begin
          stateNxt = IDLE;
          gntNxt   = '0;
          rLastNxt = 1'b1;
        end
      end
      default: stateNxt = KEY_LOAD;
    endcase
  end

  // Read-address mux: key expansion owns port 1 while loading, the granted
  // engine owns both ports; in IDLE the read registers hold.
  always_comb begin
    rdEn1  = 1'b0;
    rdEn2  = 1'b0;
    raddr1 = '0;
    raddr2 = '0;
    case (state)
      KEY_LOAD: begin
        rdEn1  = 1'b1;
        raddr1 = bus.iKey_raddr;
      end
      GRANT_C: begin
        rdEn1  = 1'b1;
        rdEn2  = 1'b1;
        raddr1 = bus.iAddr1_c;
        raddr2 = bus.iAddr2_c;
      end
      GRANT_D: begin
        rdEn1  = 1'b1;
        rdEn2  = 1'b1;
        raddr1 = bus.iAddr1_d;
        raddr2 = bus.iAddr2_d;
      end
      default: ;
    endcase
  end

  // The table is only writable while a key is being loaded.
  assign ramWe = bus.iKey_we && (state == KEY_LOAD);

  rc5_s_ram #(
    .W  (W),
    .T  (T),
    .AW (T_LENGTH)
  ) uRam (
    .clk    (clk),
    .rst    (rst),
    .we     (ramWe),
    .waddr  (bus.iKey_waddr),
    .wdata  (bus.iKey_wdata),
    .rdEn1  (rdEn1),
    .raddr1 (raddr1),
    .rdEn2  (rdEn2),
    .raddr2 (raddr2),
    .rdata1 (bus.oS_sub_i1),
    .rdata2 (bus.oS_sub_i2)
  );

  assign bus.oGnt       = gnt;
  assign bus.oKey_valid = keyValid;

endmodule
